bin_act_packer: RTL and testbench

BIN_ACT_PACKER -- requirements
Module: bin_act_packer

---
 rtl/bin_act_packer.sv | 134 +++++++++++++
 tb/tb_bin_act_packer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin_act_packer.sv
// Binary activation packer: collects single-bit activations LSB-first into
// WORD_W-bit words and queues the finished words in a small output FIFO.
// A word is closed either when it fills up or when flush_in ends a partial
// word; flushed words are tagged with word_last.
module bin_act_packer #(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            bit_valid,
    input  logic                            bit_in,
    input  logic                            flush_in,
    input  logic                            clear_err,
    output logic [WORD_W-1:0]               word_out,
    output logic                            word_last,
    output logic                            word_valid,
    input  logic                            word_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow_err
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WORD_W - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    // Packing state
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] pack_reg;

    // FIFO state; each entry carries the word plus its last tag
    logic [WORD_W-1:0] fifo_word [FIFO_DEPTH];
    logic              fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    // Derived control
    logic [WORD_W-1:0] merged_word;
    logic              word_done;
    logic              flush_push;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              accept;
    logic              overflow;

    // Combine the pack register with this cycle's bit and decide push/pop.
    // NOTE: every signal assigned in always_comb gets a default at the top so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        merged_word = pack_reg;
        if (bit_valid) begin
            merged_word[bit_cnt] = bit_in;
        end
        word_done  = bit_valid && (bit_cnt == LAST_BIT);
        flush_push = flush_in && ((bit_cnt != '0) || bit_valid);
        push       = word_done || flush_push;
        pop        = word_valid && word_ready;
        fifo_full  = (count == FULL_COUNT);
        accept     = push && (!fifo_full || pop);
        overflow   = push && fifo_full && !pop;
    end

    // Bit counter and pack register advance only on valid bits; any push
    // (full word or flush) restarts packing at bit 0 with a clean register.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt  <= '0;
            pack_reg <= '0;
        end else if (push) begin
            bit_cnt  <= '0;
            pack_reg <= '0;
        end else if (bit_valid) begin
            bit_cnt  <= bit_cnt + CNT_W'(1);
            pack_reg <= merged_word;
        end
    end

    // FIFO storage writes; a dropped word leaves the contents untouched.
    // NOTE: the storage array has no reset; word_out is gated by word_valid
    // so stale entries are never visible after reset.
    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            fifo_word[wr_ptr] <= merged_word;
            fifo_last[wr_ptr] <= flush_push;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; a new overflow wins over a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_err <= 1'b0;
        end else if (overflow) begin
            overflow_err <= 1'b1;
        end else if (clear_err) begin
            overflow_err <= 1'b0;
        end
    end

    // Head-of-FIFO outputs, forced to zero while the FIFO is empty.
    always_comb begin
        word_valid = (count != '0);
        word_out   = word_valid ? fifo_word[rd_ptr] : '0;
        word_last  = word_valid ? fifo_last[rd_ptr] : 1'b0;
        fifo_count = count;
    end

endmodule

// File: tb/tb_bin_act_packer.sv
// Directed testbench for bin_act_packer with hand-computed expected values.
module tb_bin_act_packer;

    logic        clock;
    logic        reset;
    logic        bit_valid;
    logic        bit_in;
    logic        flush_in;
    logic        clear_err;
    logic [15:0] word_out;
    logic        word_last;
    logic        word_valid;
    logic        word_ready;
    logic [2:0]  fifo_count;
    logic        overflow_err;

    int checks;
    int failures;

    bin_act_packer #(
        .WORD_W    (16),
        .FIFO_DEPTH(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .flush_in    (flush_in),
        .clear_err   (clear_err),
        .word_out    (word_out),
        .word_last   (word_last),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .fifo_count  (fifo_count),
        .overflow_err(overflow_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Send the low n bits of w, LSB first.
    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(w[i]);
        end
    endtask

    task automatic pop_once();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] pattern;
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        flush_in   = 1'b0;
        clear_err  = 1'b0;
        word_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow_err), 32'd0);
        check("rst_word", 32'(word_out), 32'h0);
        check("rst_last", 32'(word_last), 32'd0);

        // Full word from the pattern 1,0,1,1,0,0,0,0,1,1,1,1,0,0,0,1
        pattern = 16'b1000_1111_0000_1101;
        send_bits(pattern, 15);
        check("w1_not_yet_valid", 32'(word_valid), 32'd0);
        send_bit(pattern[15]);
        check("w1_word", 32'(word_out), 32'h8F0D);
        check("w1_last", 32'(word_last), 32'd0);
        check("w1_valid", 32'(word_valid), 32'd1);
        check("w1_count", 32'(fifo_count), 32'd1);
        tick();
        check("w1_hold", 32'(word_out), 32'h8F0D);
        pop_once();
        check("w1_popped", 32'(fifo_count), 32'd0);

        // Partial word 1,1,1 closed by a flush with no bit
        send_bits(16'h0007, 3);
        check("p_pending", 32'(word_valid), 32'd0);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check("p_word", 32'(word_out), 32'h0007);
        check("p_last", 32'(word_last), 32'd1);
        check("p_count", 32'(fifo_count), 32'd1);
        pop_once();
        send_bits(16'hA5C3, 16);
        check("after_flush_word", 32'(word_out), 32'hA5C3);
        check("after_flush_last", 32'(word_last), 32'd0);
        pop_once();

        // Flush on an empty packer does nothing
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check("idle_flush_count", 32'(fifo_count), 32'd0);

        // Flush coinciding with the 16th bit: exactly one word, last=1
        send_bits(16'h9234, 15);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        flush_in  = 1'b1;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        flush_in  = 1'b0;
        check("fw_count", 32'(fifo_count), 32'd1);
        check("fw_word", 32'(word_out), 32'h9234);
        check("fw_last", 32'(word_last), 32'd1);
        tick();
        check("fw_single", 32'(fifo_count), 32'd1);
        pop_once();

        // Fill the FIFO, then overflow with a fifth word
        send_bits(16'h1111, 16);
        send_bits(16'h2222, 16);
        send_bits(16'h3333, 16);
        send_bits(16'h4444, 16);
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_no_ovf", 32'(overflow_err), 32'd0);
        send_bits(16'h5555, 16);
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_flag", 32'(overflow_err), 32'd1);
        check("ovf_head", 32'(word_out), 32'h1111);
        tick();
        check("ovf_sticky", 32'(overflow_err), 32'd1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("ovf_cleared", 32'(overflow_err), 32'd0);

        // Overflow and clear in the same cycle: set wins
        send_bits(16'h7777, 15);
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        clear_err = 1'b1;
        tick();
        bit_valid = 1'b0;
        clear_err = 1'b0;
        check("set_wins", 32'(overflow_err), 32'd1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("reclear", 32'(overflow_err), 32'd0);

        // Full FIFO with a push and pop together
        send_bits(16'h6666, 15);
        bit_valid  = 1'b1;
        bit_in     = 1'b0;
        word_ready = 1'b1;
        tick();
        bit_valid  = 1'b0;
        word_ready = 1'b0;
        check("pp_count", 32'(fifo_count), 32'd4);
        check("pp_ovf", 32'(overflow_err), 32'd0);
        check("pp_head", 32'(word_out), 32'h2222);
        pop_once();
        check("drain_3333", 32'(word_out), 32'h3333);
        pop_once();
        check("drain_4444", 32'(word_out), 32'h4444);
        pop_once();
        check("drain_6666", 32'(word_out), 32'h6666);
        pop_once();
        check("drain_empty", 32'(fifo_count), 32'd0);

        // Reset mid-word with two words queued
        send_bits(16'hAAAA, 16);
        send_bits(16'h5555, 16);
        send_bits(16'h007F, 7);
        check("pre_rst_count", 32'(fifo_count), 32'd2);
        reset = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        flush_in  = 1'b1;
        tick();
        reset     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        flush_in  = 1'b0;
        check("mid_rst_valid", 32'(word_valid), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_word", 32'(word_out), 32'h0);
        send_bits(16'h0F0F, 16);
        check("post_rst_word", 32'(word_out), 32'h0F0F);
        check("post_rst_last", 32'(word_last), 32'd0);
        check("post_rst_count", 32'(fifo_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
